// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-locked round-robin arbiter sharing one FIFO
// write port among NUM_REQ requesters.
//
// Optional feature macro: ARB_BURST_LIMIT_EN
//   defined   - a grant also ends after MAX_BURST transfers, so long packets
//               may interleave with other requesters.
//   undefined - a grant ends only on a transfer flagged last.
//
// The owner's handshake is steered combinationally onto the FIFO port so the
// first word can move in the first BUSY cycle at one word per clock.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH    = 12,
    parameter int NUM_REQ       = 4,
    parameter int LOG2NUM_REQ   = 2,
    parameter int MAX_BURST     = 16,
    parameter int LOG2MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_rts,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_rtr,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_rts,
    input  logic                          fifo_rtr,
    output logic [LOG2NUM_REQ-1:0]        grant_id,
    output logic                          grant_valid
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_r;
    logic [LOG2NUM_REQ-1:0]  grant_id_r;
    logic [LOG2NUM_REQ-1:0]  last_winner_r;
    logic [LOG2NUM_REQ-1:0]  pick_s;
    logic [LOG2NUM_REQ-1:0]  cand_s;
    logic                    any_rts_s;
    logic [NUM_REQ-1:0]      sel_s;
    logic                    own_rts_s;
    logic                    own_last_s;
    logic [DATA_WIDTH-1:0]   own_data_s;
    logic                    busy_s;
    logic                    xfc_s;
    logic                    burst_done_s;

    // Round-robin search: scanning from the farthest candidate back to the
    // nearest leaves the first set bit after last_winner as the winner.
    always_comb begin
        pick_s    = {LOG2NUM_REQ{1'b0}};
        cand_s    = {LOG2NUM_REQ{1'b0}};
        any_rts_s = |req_rts;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = LOG2NUM_REQ'((int'(last_winner_r) + k) % NUM_REQ);
            if (req_rts[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Select the owner's inputs and drive the FIFO port while BUSY
    always_comb begin
        busy_s     = (state_r == BUSY);
        own_rts_s  = 1'b0;
        own_last_s = 1'b0;
        own_data_s = {DATA_WIDTH{1'b0}};
        sel_s      = {NUM_REQ{1'b0}};
        req_rtr    = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_s[i]   = (grant_id_r == LOG2NUM_REQ'(i));
            own_rts_s  = own_rts_s  | (sel_s[i] & req_rts[i]);
            own_last_s = own_last_s | (sel_s[i] & req_last[i]);
            own_data_s = own_data_s
                       | ({DATA_WIDTH{sel_s[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
            req_rtr[i] = busy_s & sel_s[i] & fifo_rtr;
        end
        fifo_rts    = busy_s & own_rts_s;
        fifo_data   = {DATA_WIDTH{busy_s}} & own_data_s;
        xfc_s       = fifo_rts & fifo_rtr;
        grant_valid = busy_s;
        grant_id    = grant_id_r;
    end

`ifdef ARB_BURST_LIMIT_EN
    logic [LOG2MAX_BURST:0] beat_cnt_r;

    // Beat counter: held at zero in IDLE so it starts clean on entry to BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= {(LOG2MAX_BURST+1){1'b0}};
        end else if (state_r == IDLE) begin
            beat_cnt_r <= {(LOG2MAX_BURST+1){1'b0}};
        end else if (xfc_s) begin
            beat_cnt_r <= beat_cnt_r + {{LOG2MAX_BURST{1'b0}}, 1'b1};
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // This transfer is the one that brings the count to MAX_BURST
    always_comb begin
        burst_done_s = xfc_s && (beat_cnt_r == (LOG2MAX_BURST+1)'(MAX_BURST - 1));
    end
`else
    // Without the burst limit only the last flag ends a grant
    always_comb begin
        burst_done_s = 1'b0;
    end
`endif

    // Arbitration FSM: grant in IDLE, hold the grant until the packet ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            grant_id_r    <= {LOG2NUM_REQ{1'b0}};
            last_winner_r <= LOG2NUM_REQ'(NUM_REQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_rts_s) begin
                        grant_id_r <= pick_s;
                        state_r    <= BUSY;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BUSY: begin
                    if (xfc_s && (own_last_s || burst_done_s)) begin
                        last_winner_r <= grant_id_r;
                        state_r       <= IDLE;
                    end else begin
                        state_r       <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed testbench for fifo_write_arbiter. Each requester is a small word
// source (data + last flag per word); every word accepted by the FIFO port is
// captured and compared with a hand-written expected order.
module tb_fifo_write_arbiter;

    localparam int DW  = 12;
    localparam int NR  = 4;
    localparam int LNR = 2;
`ifdef ARB_BURST_LIMIT_EN
    localparam int MB  = 4;
    localparam int LMB = 2;
`else
    localparam int MB  = 16;
    localparam int LMB = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_rts;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_rtr;
    logic [DW-1:0]     fifo_data;
    logic              fifo_rts;
    logic              fifo_rtr;
    logic [LNR-1:0]    grant_id;
    logic              grant_valid;

    fifo_write_arbiter #(
        .DATA_WIDTH    (DW),
        .NUM_REQ       (NR),
        .LOG2NUM_REQ   (LNR),
        .MAX_BURST     (MB),
        .LOG2MAX_BURST (LMB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (req_data),
        .req_rts     (req_rts),
        .req_last    (req_last),
        .req_rtr     (req_rtr),
        .fifo_data   (fifo_data),
        .fifo_rts    (fifo_rts),
        .fifo_rtr    (fifo_rtr),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int              checks = 0;
    int              passes = 0;
    logic [DW:0]     src_mem [NR][32];
    int              src_len [NR];
    int              src_ptr [NR];
    logic [NR-1:0]   hold;
    logic [NR-1:0]   fired;
    logic [DW-1:0]   got[$];
    logic [DW-1:0]   exp_q[$];
    logic [LNR-1:0]  grants[$];
    logic            gv_trace[$];
    logic            prev_gv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_packet(input int r, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            src_mem[r][src_len[r]] = {(k == n - 1), DW'(base + k)};
            src_len[r]++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_ptr[i] < src_len[i] && !hold[i]) begin
                req_rts[i]             = 1'b1;
                req_last[i]            = src_mem[i][src_ptr[i]][DW];
                req_data[i*DW +: DW]   = src_mem[i][src_ptr[i]][DW-1:0];
            end else begin
                req_rts[i]             = 1'b0;
                req_last[i]            = 1'b0;
                req_data[i*DW +: DW]   = '0;
            end
        end
    endtask

    // One clock: observe at the falling edge, advance sources after the rising edge
    task automatic step();
        @(negedge clk);
        if (fifo_rts && fifo_rtr) got.push_back(fifo_data);
        if (grant_valid && !prev_gv) grants.push_back(grant_id);
        gv_trace.push_back(grant_valid);
        prev_gv = grant_valid;
        fired   = req_rts & req_rtr;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fired[i]) src_ptr[i]++;
        end
        drive_inputs();
    endtask

    task automatic clear_obs();
        got.delete();
        grants.delete();
        gv_trace.delete();
        exp_q.delete();
        prev_gv = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fifo_rtr = 1'b1;
        hold     = '0;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        drive_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic check_words(input string tag);
        check_eq({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check_eq($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset state, with every requester already asking
        rst      = 1'b1;
        fifo_rtr = 1'b1;
        hold     = '0;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            add_packet(i, 1, 12'h0A0 + i);
        end
        drive_inputs();
        #2;
        check_eq("rst_gv",    32'(grant_valid), 32'd0);
        check_eq("rst_rts",   32'(fifo_rts),    32'd0);
        check_eq("rst_rtr",   32'(req_rtr),     32'd0);
        check_eq("rst_data",  32'(fifo_data),   32'd0);
        check_eq("rst_gid",   32'(grant_id),    32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_gv_clk", 32'(grant_valid), 32'd0);

        // Requesters 0 and 2, three-word packets
        do_reset();
        add_packet(0, 3, 12'h100);
        add_packet(2, 3, 12'h200);
        drive_inputs();
        repeat (10) step();
        exp_q = '{12'h100, 12'h101, 12'h102, 12'h200, 12'h201, 12'h202};
        check_words("t1");
        check_eq("t1_ngrant", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            check_eq("t1_g0", 32'(grants[0]), 32'd0);
            check_eq("t1_g1", 32'(grants[1]), 32'd2);
        end
        check_eq("t1_idle0", 32'(gv_trace[0]), 32'd0);
        check_eq("t1_busy1", 32'(gv_trace[1]), 32'd1);
        check_eq("t1_busy3", 32'(gv_trace[3]), 32'd1);
        check_eq("t1_gap",   32'(gv_trace[4]), 32'd0);
        check_eq("t1_busy5", 32'(gv_trace[5]), 32'd1);

        // All four requesters, single-word packets, rotating grant
        do_reset();
        for (int i = 0; i < NR; i++) begin
            add_packet(i, 1, 12'h010 + i);
            add_packet(i, 1, 12'h020 + i);
        end
        drive_inputs();
        repeat (18) step();
        exp_q = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h020, 12'h021, 12'h022, 12'h023};
        check_words("t2");
        check_eq("t2_ngrant", 32'(grants.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grants.size()) check_eq($sformatf("t2_g%0d", i), 32'(grants[i]), 32'(i % NR));
            check_eq($sformatf("t2_gv%0d", i), 32'(gv_trace[i]), 32'(i % 2));
        end

        // FIFO full for five cycles in the middle of requester 1's packet
        do_reset();
        add_packet(1, 4, 12'h300);
        drive_inputs();
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            fifo_rtr = 1'b0;
            #1;
            check_eq($sformatf("t3_rts%0d", c), 32'(fifo_rts), 32'd1);
            check_eq($sformatf("t3_rtr%0d", c), 32'(req_rtr),  32'd0);
            step();
        end
        fifo_rtr = 1'b1;
        repeat (6) step();
        exp_q = '{12'h300, 12'h301, 12'h302, 12'h303};
        check_words("t3");

        // Requester 3 pauses mid-packet while requester 0 waits
        do_reset();
        add_packet(3, 4, 12'h400);
        drive_inputs();
        step();
        step();
        add_packet(0, 2, 12'h500);
        hold[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_inputs();
            #1;
            check_eq($sformatf("t4_gid%0d", c),  32'(grant_id),   32'd3);
            check_eq($sformatf("t4_gv%0d", c),   32'(grant_valid), 32'd1);
            check_eq($sformatf("t4_rtr0_%0d", c), 32'(req_rtr[0]), 32'd0);
            check_eq($sformatf("t4_frts%0d", c), 32'(fifo_rts),    32'd0);
            step();
        end
        hold = '0;
        drive_inputs();
        repeat (10) step();
        exp_q = '{12'h400, 12'h401, 12'h402, 12'h403, 12'h500, 12'h501};
        check_words("t4");
        check_eq("t4_ngrant", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            check_eq("t4_g0", 32'(grants[0]), 32'd3);
            check_eq("t4_g1", 32'(grants[1]), 32'd0);
        end

        // Reset pulse in the middle of requester 2's packet
        do_reset();
        add_packet(2, 4, 12'h600);
        drive_inputs();
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("t5_gv",  32'(grant_valid), 32'd0);
        check_eq("t5_rts", 32'(fifo_rts),    32'd0);
        check_eq("t5_rtr", 32'(req_rtr),     32'd0);
        add_packet(0, 1, 12'h800);
        drive_inputs();
        step();
        rst = 1'b0;
        clear_obs();
        repeat (8) step();
        exp_q = '{12'h800, 12'h602, 12'h603};
        check_words("t5");
        check_eq("t5_ngrant", 32'(grants.size()), 32'd2);
        if (grants.size() >= 1) check_eq("t5_g0", 32'(grants[0]), 32'd0);

        // Long packet from requester 0 against a short one from requester 1
        do_reset();
        add_packet(0, 10, 12'h900);
        add_packet(1, 2, 12'hA00);
        drive_inputs();
        repeat (20) step();
`ifdef ARB_BURST_LIMIT_EN
        exp_q = '{12'h900, 12'h901, 12'h902, 12'h903, 12'hA00, 12'hA01,
                  12'h904, 12'h905, 12'h906, 12'h907, 12'h908, 12'h909};
        check_words("t6");
        check_eq("t6_ngrant", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            check_eq("t6_g1", 32'(grants[1]), 32'd1);
            check_eq("t6_g2", 32'(grants[2]), 32'd0);
        end
`else
        exp_q = '{12'h900, 12'h901, 12'h902, 12'h903, 12'h904, 12'h905,
                  12'h906, 12'h907, 12'h908, 12'h909, 12'hA00, 12'hA01};
        check_words("t6");
        check_eq("t6_ngrant", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            check_eq("t6_g0", 32'(grants[0]), 32'd0);
            check_eq("t6_g1", 32'(grants[1]), 32'd1);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares one FIFO write port (data / rts / rtr handshake) among NUM_REQ requesters, such as the rasteriser, the blitter and the command parser.
- Arbitration is packet-locked: once a requester is granted, only its words enter the FIFO until it transfers a word flagged last. Packets from different requesters therefore never interleave in the FIFO.
- The block sits directly in front of the FIFO input interface: fifo_data drives FIFO in_data, fifo_rts drives in_rts, and FIFO in_rtr drives fifo_rtr.

Parameters:
- DATA_WIDTH, 12, word width of every requester and of the FIFO.
- NUM_REQ, 4, number of requesters (2 to 8).
- LOG2NUM_REQ, 2, width of the grant index.
- MAX_BURST, 16, word limit per grant; used only when ARB_BURST_LIMIT_EN is defined.
- LOG2MAX_BURST, 4, width of the burst counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_rts  input  NUM_REQ  requester i is ready to send.
- req_last  input  NUM_REQ  the current word of requester i ends its packet.
- req_rtr  output  NUM_REQ  the arbiter is ready to receive from requester i.
- fifo_data  output  DATA_WIDTH  to FIFO in_data.
- fifo_rts  output  1  to FIFO in_rts.
- fifo_rtr  input  1  from FIFO in_rtr.
- grant_id  output  LOG2NUM_REQ  index of the current owner.
- grant_valid  output  1  high while in state BUSY.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, grant_id = 0, last_winner = NUM_REQ-1 (so requester 0 has first priority), beat counter = 0.
  - Outputs: grant_valid = 0, req_rtr = 0, fifo_rts = 0, fifo_data = 0.
- State IDLE:
  - All req_rtr = 0 and fifo_rts = 0.
  - If any req_rts bit is set, pick the first set bit searching upward from (last_winner+1) mod NUM_REQ, with wrap-around.
  - Register that index into grant_id and move to BUSY on the next edge.
  - If no bit is set, stay in IDLE.
- State BUSY, with g = grant_id:
  - Outputs are combinational: fifo_rts = req_rts[g], fifo_data = slice g of req_data, req_rtr[g] = fifo_rtr, all other req_rtr bits = 0.
  - A transfer (xfc) occurs in any cycle where fifo_rts and fifo_rtr are both high.
- Leaving BUSY:
  - An xfc with req_last[g] = 1 sends the block to IDLE and sets last_winner <= g.
  - An xfc with req_last[g] = 0 keeps the block in BUSY.
- Owner stalls: if req_rts[g] drops mid-packet, the block stays in BUSY with no transfers. The grant is held indefinitely; there is no timeout.
- FIFO full: fifo_rtr = 0 stalls the owner through req_rtr[g] = 0. No word is dropped and no word is duplicated.
- Latency: 1 arbitration cycle in IDLE between packets. The first word of a packet can transfer in the first BUSY cycle. Throughput within a packet is 1 word per clock.
- Single-word packet (last = 1 on the first word): BUSY lasts exactly 1 cycle when fifo_rtr = 1.
- Inputs from requesters other than g are ignored while BUSY. A request that arrives mid-packet is considered at the next IDLE cycle.
- Reset asserted mid-packet: the partial packet is abandoned. The FIFO keeps any words already written; cleaning them up is the system's responsibility.
- Fairness: every requester that holds rts is granted within NUM_REQ-1 intervening packets.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- Defined:
  - A LOG2MAX_BURST+1-bit beat counter clears on entry to BUSY and increments on each xfc.
  - The xfc that brings the count to MAX_BURST forces a return to IDLE and sets last_winner <= g, even when req_last is low.
  - The requester keeps rts high and competes again for the remainder of its packet. Packets longer than MAX_BURST may therefore interleave with other requesters.
- Not defined:
  - The counter is absent.
  - A grant ends only on an xfc with last = 1.

Test Plan:
- Reset, then req_rts = 4'b0101, both sending 3-word packets, fifo_rtr = 1 → requester 0 is granted first. The FIFO receives r0 w0..w2, then one idle cycle, then r2 w0..w2. grant_id sequence is 0, 2.
- All 4 requesters hold rts continuously with single-word packets → grant_id is 0,1,2,3,0,… with grant_valid alternating 1,0 each cycle.
- Requester 1 in BUSY with fifo_rtr held 0 for 5 cycles mid-packet → fifo_rts = 1 and req_rtr[1] = 0 throughout. After release the words are written in order with no loss or duplicates.
- Requester 3 drops rts for 3 cycles mid-packet while requester 0 requests → grant stays 3 and requester 0 gets req_rtr = 0. Requester 0 is granted only after r3's last word.
- rst pulsed in the middle of a 4-word packet → grant_valid, fifo_rts and req_rtr go to 0 immediately. After reset, requester 0 has first priority.
- ARB_BURST_LIMIT_EN defined with MAX_BURST = 4: requester 0 sends a 10-word packet and requester 1 sends a 2-word packet → FIFO order is r0×4, r1×2, r0×4, r0×2.
